uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   UART receiver, 8N1, LSB first. Recovers bytes from the asynchronous serial line RXD.
//   Each byte is presented on Data with a one-cycle Data_valid strobe.
//   Sits beside the UART transmitter in the uart block and uses the same bit-period arithmetic:
//   one bit = P = FREQ_CLK/RX_SPEED + 1 clock cycles.
// PARAMETERS
//   FREQ_CLK  100000000  system clock frequency in Hz (logic [31:0])
//   RX_SPEED  115200     line baud rate in bit/s (logic [31:0])
//   localparam PULSE_END_OF_COUNT = FREQ_CLK/RX_SPEED; one bit lasts PULSE_END_OF_COUNT+1 cycles
//   localparam HALF_COUNT = PULSE_END_OF_COUNT/2 (integer division)
// PORTS
//   Clk         in   1  system clock, rising edge
//   Rst_n       in   1  synchronous active-low reset
//   RXD         in   1  serial line, asynchronous, idles high
//   Data        out  8  last correctly framed byte; holds until the next good frame
//   Data_valid  out  1  one-cycle pulse when Data updates
//   Frame_err   out  1  one-cycle pulse when the stop bit is sampled low
//   Busy        out  1  high whenever state != IDLE
//   Parity_err  out  1  exists only with UART_RX_PARITY_EN
// BEHAVIOUR
//   - Reset values: Data=0, Data_valid=0, Frame_err=0, Busy=0, Parity_err=0, state=IDLE.
//     Synchronizer flops reset to 1. Counters reset to 0.
//   - RXD passes through a 2-FF synchronizer (rx_s) before any use. Add 2 cycles to all latencies.
//   - period_cnt: counts 0..PULSE_END_OF_COUNT and wraps to 0. Held at 0 in IDLE.
//     Cleared on every state change.
//   - bit_cnt: 0..7, counts data bits. Cleared outside RECV_DATA.
//   - FSM (state_t, enum logic[2:0]):
//     IDLE:      rx_s==0 -> START_BIT.
//     START_BIT: at period_cnt==HALF_COUNT, sample rx_s.
//                0 -> RECV_DATA (period_cnt cleared). 1 -> IDLE (glitch rejected, no pulse).
//     RECV_DATA: at period_cnt==PULSE_END_OF_COUNT, shift rx_s into shift_reg[bit_cnt].
//                After the bit_cnt==7 sample -> STOP_BIT (or PARITY_BIT if the macro is defined).
//     STOP_BIT:  at period_cnt==PULSE_END_OF_COUNT, sample rx_s.
//                1 -> Data<=shift_reg and Data_valid=1 on the next cycle.
//                0 -> Frame_err=1 on the next cycle; Data unchanged.
//                Either way -> IDLE.
//   - Samples fall mid-bit. IDLE is re-entered half a bit before the stop bit ends,
//     so back-to-back frames with no idle gap are received.
//   - A low line seen in IDLE right after a framing error starts a new frame
//     (break and continuous-low lines retrigger).
//   - Data_valid and Frame_err are registered and never assert in the same cycle.
//   - Rst_n low at any point (mid-frame included): the FSM goes to IDLE on the next edge,
//     the partial byte is discarded, no pulse is emitted.
// CONFIGURATION
//   UART_RX_PARITY_EN defined:
//     - A PARITY_BIT state sits between RECV_DATA and STOP_BIT.
//     - The parity bit is sampled at period_cnt==PULSE_END_OF_COUNT.
//     - Even parity: error when ^{shift_reg, parity_bit} != 0.
//     - At the stop-bit sample, Parity_err pulses for one cycle together with Data_valid.
//       Data still updates, so the consumer decides.
//     - A frame with a bad stop bit gives Frame_err only.
//   UART_RX_PARITY_EN undefined:
//     - 8N1 only. No PARITY_BIT state and no Parity_err port.
// TESTING (FREQ_CLK=1000000, RX_SPEED=100000 -> 11 cycles/bit, HALF_COUNT=5)
//   1. Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop)
//      -> exactly one Data_valid, Data=0xA5, Frame_err=0, Busy back to 0.
//   2. Pull RXD low for 3 cycles, then high
//      -> Busy pulses, Data_valid=0, Frame_err=0, Data unchanged.
//   3. Frame 0x3C with stop bit driven 0
//      -> Frame_err one cycle, Data_valid=0, Data keeps its previous value.
//   4. Back-to-back 0x00 then 0xFF with no idle gap
//      -> two Data_valid pulses, Data=0x00 then 0xFF.
//   5. Assert Rst_n=0 for 2 cycles during bit 4 of 0x81, then send 0x42 cleanly
//      -> no pulse for 0x81; one Data_valid with Data=0x42.
//   6. UART_RX_PARITY_EN: send 0x07 with parity 1, then 0x07 with parity 0
//      -> first Data_valid with Parity_err=0, second Data_valid with Parity_err=1.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-FF input synchronizer and mid-bit sampling.
// Optional even-parity checking is built in when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter logic [31:0] FREQ_CLK = 32'd100000000,
    parameter logic [31:0] RX_SPEED = 32'd115200
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       RXD,
    output logic [7:0] Data,
    output logic       Data_valid,
    output logic       Frame_err,
    output logic       Busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       Parity_err
`endif
);

    localparam logic [31:0] PULSE_END_OF_COUNT = FREQ_CLK / RX_SPEED;
    localparam logic [31:0] HALF_COUNT         = PULSE_END_OF_COUNT / 2;
    localparam int          CNT_W = (PULSE_END_OF_COUNT < 32'd2) ? 1 : $clog2(PULSE_END_OF_COUNT + 32'd1);
    localparam logic [CNT_W-1:0] CNT_END  = PULSE_END_OF_COUNT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_HALF = HALF_COUNT[CNT_W-1:0];

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] START_BIT  = 3'd1;
    localparam logic [2:0] RECV_DATA  = 3'd2;
    localparam logic [2:0] STOP_BIT   = 3'd3;
    localparam logic [2:0] PARITY_BIT = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] AFTER_DATA = PARITY_BIT;
`else
    localparam logic [2:0] AFTER_DATA = STOP_BIT;
`endif

    logic             rx_meta;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] period_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             cnt_end;
    logic             cnt_half;
`ifdef UART_RX_PARITY_EN
    logic             parity_bit;
`endif

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rx_s    <= rx_meta;
        end
    end

    assign cnt_end  = (period_cnt == CNT_END);
    assign cnt_half = (period_cnt == CNT_HALF);
    assign Busy     = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state      <= IDLE;
            period_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            Data       <= '0;
            Data_valid <= 1'b0;
            Frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit <= 1'b0;
            Parity_err <= 1'b0;
`endif
        end else begin
            Data_valid <= 1'b0;
            Frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            Parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    period_cnt <= '0;
                    bit_cnt    <= '0;
                    if (!rx_s) state <= START_BIT;
                end
                START_BIT: begin
                    if (cnt_half) begin
                        period_cnt <= '0;
                        state      <= rx_s ? IDLE : RECV_DATA;
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                end
                RECV_DATA: begin
                    // Counter started at mid start bit, so each wrap lands mid data bit.
                    if (cnt_end) begin
                        period_cnt         <= '0;
                        shift_reg[bit_cnt] <= rx_s;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= AFTER_DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY_BIT: begin
                    if (cnt_end) begin
                        period_cnt <= '0;
                        parity_bit <= rx_s;
                        state      <= STOP_BIT;
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                end
`endif
                STOP_BIT: begin
                    // Leaving at mid stop bit lets a gapless next start bit be caught.
                    if (cnt_end) begin
                        period_cnt <= '0;
                        state      <= IDLE;
                        if (rx_s) begin
                            Data       <= shift_reg;
                            Data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            Parity_err <= ^{shift_reg, parity_bit};
`endif
                        end else begin
                            Frame_err <= 1'b1;
                        end
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    period_cnt <= '0;
                    bit_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 11 clocks per bit; a scoreboard queue holds
// expected {parity_err, frame_err, data} results, popped by a pulse monitor.
module tb_uart_rx;

    localparam int BIT_CYC = 11;

    logic       Clk;
    logic       Rst_n;
    logic       RXD;
    logic [7:0] Data;
    logic       Data_valid;
    logic       Frame_err;
    logic       Busy;
    logic       perr_obs;
`ifdef UART_RX_PARITY_EN
    logic       Parity_err;
    assign perr_obs = Parity_err;
`else
    assign perr_obs = 1'b0;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] exp_q[$];
    logic       busy_seen;

    uart_rx #(
        .FREQ_CLK(32'd1000000),
        .RX_SPEED(32'd100000)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .RXD       (RXD),
        .Data      (Data),
        .Data_valid(Data_valid),
        .Frame_err (Frame_err),
        .Busy      (Busy)
`ifdef UART_RX_PARITY_EN
        ,
        .Parity_err(Parity_err)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        RXD = v;
        repeat (BIT_CYC) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input logic use_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (use_par) send_bit(par);
        send_bit(stop);
    endtask

    task automatic settle;
        RXD = 1'b1;
        repeat (30) @(negedge Clk);
        check("idle_busy", 32'(Busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // 10'h3FF never occurs as an expectation, so an unexpected pulse always miscompares.
    always @(negedge Clk) begin
        logic [9:0] e;
        if (Rst_n && (Data_valid || Frame_err)) begin
            check("dv_fe_exclusive", 32'(Data_valid & Frame_err), 32'd0);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
            check("rx_pulse", 32'({perr_obs, Frame_err, Data}), 32'(e));
        end
    end

    initial begin
        Rst_n = 1'b0;
        RXD   = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_data", 32'(Data), 32'd0);
        check("rst_valid", 32'(Data_valid), 32'd0);
        check("rst_ferr", 32'(Frame_err), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        Rst_n = 1'b1;
        repeat (5) @(negedge Clk);

        // clean frame
        exp_q.push_back({2'b00, 8'hA5});
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        settle();

        // short low glitch
        busy_seen = 1'b0;
        RXD = 1'b0;
        repeat (3) @(negedge Clk);
        RXD = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Busy) busy_seen = 1'b1;
        end
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_data_kept", 32'(Data), 32'hA5);
        settle();

        // bad stop bit
        exp_q.push_back({2'b01, 8'hA5});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        settle();
        check("ferr_data_kept", 32'(Data), 32'hA5);

        // back-to-back frames
        exp_q.push_back({2'b00, 8'h00});
        exp_q.push_back({2'b00, 8'hFF});
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        settle();

        // reset during bit 4 of 0x81; the sender is aborted along with it
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 1; i < 4; i++) send_bit(1'b0);
        RXD = 1'b0;
        repeat (5) @(negedge Clk);
        Rst_n = 1'b0;
        RXD   = 1'b1;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("midreset_data", 32'(Data), 32'd0);
        check("midreset_busy", 32'(Busy), 32'd0);
        repeat (20) @(negedge Clk);
        exp_q.push_back({2'b00, 8'h42});
        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        settle();
        check("final_data", 32'(Data), 32'h42);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back({2'b00, 8'h07});
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        exp_q.push_back({2'b10, 8'h07});
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        settle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
